// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues one word fetch at a time to instruction memory,
// buffers returned instructions with their PCs and hands them to decode.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  output logic                   inst_valid,
  output logic [31:0]            inst,
  output logic [31:0]            inst_pc,
  input  logic                   inst_ready,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             dbgState
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     fetchPc;
  logic [PW-1:0]   headPtr;
  logic [PW-1:0]   tailPtr;
  logic [CW-1:0]   occupancy;
  logic [31:0]     instMem [DEPTH];
  logic [31:0]     pcMem   [DEPTH];

  logic            doPush;
  logic            doPop;
  logic [CW-1:0]   countNext;
  logic            hasCredit;

  // Handshakes: a fetch completes on a cycle where mem_req && mem_ack (mem_addr is held
  // until then); decode takes the head on a cycle where inst_valid && inst_ready.
  // A redirect overrides both: acked data is discarded and the head is not consumed.
  always_comb begin
    doPop     = inst_valid && inst_ready && !redirect;
    doPush    = (state == REQ) && mem_ack && !redirect;
    countNext = occupancy + CW'(doPush) - CW'(doPop);
    hasCredit = countNext < CW'(DEPTH);
  end

  assign inst_valid = (occupancy != '0);
  assign inst       = instMem[headPtr];
  assign inst_pc    = pcMem[headPtr];
  assign count      = occupancy;
  assign dbgState   = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      fetchPc   <= RESET_PC;
      occupancy <= '0;
      headPtr   <= '0;
      tailPtr   <= '0;
    end else if (redirect) begin
      occupancy <= '0;
      headPtr   <= '0;
      tailPtr   <= '0;
      fetchPc   <= redirect_pc;
      case (state)
        REQ: begin
          // An unacked fetch is still owned by memory; wait it out before retargeting.
          if (mem_ack) mem_addr <= redirect_pc;
          else state <= DROP;
        end
        DROP: state <= DROP;
        default: begin
          state    <= REQ;
          mem_req  <= 1'b1;
          mem_addr <= redirect_pc;
        end
      endcase
    end else begin
      occupancy <= countNext;
      if (doPush) tailPtr <= tailPtr + PW'(1);
      if (doPop)  headPtr <= headPtr + PW'(1);
      case (state)
        IDLE: begin
          if (hasCredit) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetchPc;
          end
        end
        REQ: begin
          if (mem_ack) begin
            fetchPc <= mem_addr + 32'd1;
            if (hasCredit) begin
              mem_addr <= mem_addr + 32'd1;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        DROP: begin
          if (mem_ack) begin
            state    <= REQ;
            mem_addr <= fetchPc;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instMem[i] <= '0;
        pcMem[i]   <= '0;
      end
    end else if (doPush) begin
      instMem[tailPtr] <= mem_rdata;
      pcMem[tailPtr]   <= mem_addr;
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage with a prefetch buffer, placed between the program-counter/instruction-memory side and the decode/control stage of the RISC-V core. It issues word fetches to a variable-latency instruction memory over a req/ack handshake, buffers up to DEPTH returned instructions with their PCs, and presents them to decode with valid/ready. A branch redirect flushes the buffer, discards any in-flight fetch and restarts fetching at the new PC.

## Interface
- DEPTH, 4, buffer entries; power of two, at least 2
- RESET_PC, 32'd0, first fetch address after reset
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- mem_req  out  1  fetch request, registered
- mem_addr  out  32  word address of the fetch, registered; stable while mem_req=1
- mem_ack  in  1  fetch complete; mem_rdata valid this cycle
- mem_rdata  in  32  fetched instruction
- inst_valid  out  1  head entry valid
- inst  out  32  head instruction
- inst_pc  out  32  address of the head instruction
- inst_ready  in  1  decode accepts head this cycle
- redirect  in  1  branch taken; flush and restart
- redirect_pc  in  32  new fetch address
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Addressing is word-granular: sequential PC = PC + 1, modulo 2^32 (0xFFFFFFFF wraps to 0x00000000).
- At most one fetch outstanding. FSM states: IDLE, REQ, DROP.
- IDLE: mem_req=0. Go to REQ with mem_addr=fetch_pc if count_next < DEPTH, where count_next is the occupancy after this cycle's pop.
- REQ: mem_req=1, mem_addr held. On mem_ack: push {mem_addr, mem_rdata} and set fetch_pc = mem_addr + 1. If count_next < DEPTH, stay in REQ with the new address; otherwise go to IDLE.
- DROP: mem_req=1 with the stale address held. On mem_ack, discard the data, then go to REQ with mem_addr = fetch_pc (the redirect target).
- Pop occurs when inst_valid && inst_ready. inst_valid = (count != 0). inst and inst_pc are read combinationally from the head entry.
- Push and pop in the same cycle: count is unchanged and both take effect.
- Redirect has priority over push and pop. On a redirect cycle:
  - Next cycle count=0. Head/tail pointers reset. fetch_pc = redirect_pc.
  - If in REQ without mem_ack: go to DROP.
  - If in REQ with mem_ack: discard the data and go to REQ with mem_addr = redirect_pc.
  - If in IDLE: go to REQ with mem_addr = redirect_pc.
  - If in DROP: stay in DROP; the latest redirect_pc wins.
  - inst_ready is ignored that cycle, and the head is not counted as consumed.
- Full: no request is issued. A full buffer never receives a push because credit is checked before issue.
- Reset values: state=IDLE, mem_req=0, mem_addr=0, fetch_pc=RESET_PC, count=0, inst_valid=0, inst=0, inst_pc=0 (storage cleared).
- Reset asserted mid-fetch aborts the fetch. A later mem_ack is ignored, since state is IDLE.

## Timing
- First mem_req rises at the first rising edge after reset deasserts, with mem_addr=RESET_PC.
- Ack-to-valid latency: 1 cycle (entry visible the cycle after mem_ack).
- Ack in the same cycle as req (zero-wait memory): sustained 1 instruction/cycle when the consumer is always ready.
- Redirect to new request: mem_req with mem_addr=redirect_pc is present the cycle after the redirect, unless a stale fetch is pending. In that case it appears the cycle after the stale mem_ack.
- mem_addr must not change while mem_req=1 and mem_ack=0.

## Test plan
- Reset, zero-wait memory returning mem_rdata = addr ^ 0xA5A5A5A5, consumer always ready -> pcs 0,1,2,3… appear on consecutive cycles, with first inst_valid 2 cycles after reset release.
- Consumer stalled (inst_ready=0) -> count reaches 4, mem_req drops to 0 and stays 0. One pop -> exactly one new fetch is issued (addr 4), and no entry is lost or duplicated.
- Memory with 3-cycle ack latency; redirect to 0x100 during the wait -> stale data is dropped, next mem_addr=0x100, and inst_pc sequence continues 0x100, 0x101.
- Redirect in the same cycle as mem_ack and a pop -> count=0 next cycle, the acked data never appears, and the next fetch address is redirect_pc.
- redirect_pc=0xFFFFFFFE, zero-wait memory -> inst_pc sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- reset pulled low while in REQ with count=2 -> outputs return to reset values immediately. After release, fetch restarts at RESET_PC.
